// File: rtl/train_pkg.sv
// Shared types for the train signalling interface.
//   aspect_t       : one-hot {green, yellow, red}, shared with the trackside signal block
//   driver_state_t : speed controller FSM state
//   speed_t        : 4-bit unsigned train speed
package train_pkg;

  typedef logic [2:0] aspect_t;

  localparam aspect_t ASPECT_GREEN  = 3'b100;
  localparam aspect_t ASPECT_YELLOW = 3'b010;
  localparam aspect_t ASPECT_RED    = 3'b001;

  typedef enum logic [2:0] {
    S_STOPPED   = 3'd0,
    S_ACCEL     = 3'd1,
    S_CRUISE    = 3'd2,
    S_DECEL     = 3'd3,
    S_EMERGENCY = 3'd4
  } driver_state_t;

  typedef logic [3:0] speed_t;

endpackage

// File: rtl/train_speed_ramp.sv
// Speed register with a step prescaler.
//   clk, rstn  : clock, async active-low reset
//   up, down   : count the prescaler; step speed +1/-1 when it wraps
//   fast_down  : decrement speed every cycle (emergency stop), floor at 0
//   clear_cnt  : force the prescaler to 0 (takes priority over counting)
//   speed      : registered current speed
module train_speed_ramp
  import train_pkg::*;
#(
  parameter int MAX_SPEED = 12,
  parameter int ACCEL_DIV = 4
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   up,
  input  logic   down,
  input  logic   fast_down,
  input  logic   clear_cnt,
  output speed_t speed
);

  localparam int CNT_W = (ACCEL_DIV > 2) ? $clog2(ACCEL_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_DIV - 1);
  localparam speed_t SPEED_MAX = speed_t'(MAX_SPEED);

  logic [CNT_W-1:0] step_cnt;
  logic             wrap;

  assign wrap = (up || down) && !clear_cnt && (step_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_cnt <= '0;
    end else if (clear_cnt || wrap || !(up || down)) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Saturation guards keep speed in 0..MAX_SPEED even if a caller misbehaves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      speed <= '0;
    end else if (fast_down) begin
      if (speed != '0) speed <= speed - 1'b1;
    end else if (wrap && up) begin
      if (speed < SPEED_MAX) speed <= speed + 1'b1;
    end else if (wrap && down) begin
      if (speed != '0) speed <= speed - 1'b1;
    end
  end

endmodule

// File: rtl/train_driver.sv
// On-board speed controller. Decodes the trackside aspect into a target speed
// and ramps the speed register toward it; a non-one-hot aspect forces an
// emergency stop.
//   clk, rstn           : clock, async active-low reset
//   green, yellow, red  : aspect from the trackside signal block
//   speed               : current speed (registered)
//   throttle            : high in ACCEL
//   brake               : high in STOPPED, DECEL, EMERGENCY
//   emergency           : high in EMERGENCY
//
// state       | meaning
// S_STOPPED   | at rest, target 0
// S_ACCEL     | stepping speed up once per ACCEL_DIV cycles
// S_CRUISE    | holding a non-zero target speed
// S_DECEL     | stepping speed down once per ACCEL_DIV cycles
// S_EMERGENCY | illegal aspect seen; speed drops 1 per cycle to 0
module train_driver
  import train_pkg::*;
#(
  parameter int MAX_SPEED     = 12,
  parameter int CAUTION_SPEED = 6,
  parameter int ACCEL_DIV     = 4
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   green,
  input  logic   yellow,
  input  logic   red,
  output speed_t speed,
  output logic   throttle,
  output logic   brake,
  output logic   emergency
);

  driver_state_t state, state_next;
  aspect_t       aspect;
  speed_t        target;
  logic          legal;
  logic          up, down, fast_down, clear_cnt;

  assign aspect = {green, yellow, red};

  always_comb begin
    legal  = 1'b1;
    target = '0;
    case (aspect)
      ASPECT_GREEN:  target = speed_t'(MAX_SPEED);
      ASPECT_YELLOW: target = speed_t'(CAUTION_SPEED);
      ASPECT_RED:    target = '0;
      default:       legal  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_STOPPED;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == S_EMERGENCY) begin
      if (legal && speed == '0) state_next = S_STOPPED;
    end else if (!legal) begin
      state_next = S_EMERGENCY;
    end else if (speed < target) begin
      state_next = S_ACCEL;
    end else if (speed > target) begin
      state_next = S_DECEL;
    end else if (speed == '0) begin
      state_next = S_STOPPED;
    end else begin
      state_next = S_CRUISE;
    end
  end

  // Stepping only while the ramp state persists: on a state change edge the
  // prescaler restarts and no step is taken.
  always_comb begin
    up        = (state == S_ACCEL) && (state_next == S_ACCEL);
    down      = (state == S_DECEL) && (state_next == S_DECEL);
    fast_down = (state == S_EMERGENCY);
    clear_cnt = (state != state_next) || !((state == S_ACCEL) || (state == S_DECEL));
  end

  train_speed_ramp #(
    .MAX_SPEED (MAX_SPEED),
    .ACCEL_DIV (ACCEL_DIV)
  ) u_ramp (
    .clk       (clk),
    .rstn      (rstn),
    .up        (up),
    .down      (down),
    .fast_down (fast_down),
    .clear_cnt (clear_cnt),
    .speed     (speed)
  );

  always_comb begin
    throttle  = (state == S_ACCEL);
    brake     = (state == S_STOPPED) || (state == S_DECEL) || (state == S_EMERGENCY);
    emergency = (state == S_EMERGENCY);
  end

endmodule

// File: tb/tb_train_driver.sv
module tb_train_driver;

  logic       clk = 1'b0;
  logic       rstn;
  logic       green, yellow, red;
  logic [3:0] speed;
  logic       throttle, brake, emergency;

  train_driver #(
    .MAX_SPEED     (12),
    .CAUTION_SPEED (6),
    .ACCEL_DIV     (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .green     (green),
    .yellow    (yellow),
    .red       (red),
    .speed     (speed),
    .throttle  (throttle),
    .brake     (brake),
    .emergency (emergency)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] spd;
    logic       thr;
    logic       brk;
    logic       emg;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: at each falling edge, compare and retire every expectation due by now.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.name, e.cyc, cyc);
      end else if (speed !== e.spd || throttle !== e.thr || brake !== e.brk || emergency !== e.emg) begin
        errors++;
        $display("FAIL %s @cyc %0d: got speed=%0d thr=%b brk=%b emg=%b, want speed=%0d thr=%b brk=%b emg=%b",
                 e.name, cyc, speed, throttle, brake, emergency, e.spd, e.thr, e.brk, e.emg);
      end
    end
  end

  task automatic expect_at(input int delta, input logic [3:0] s, input logic t, input logic b,
                           input logic em, input string nm);
    exp_t e;
    e.cyc = cyc + delta; e.spd = s; e.thr = t; e.brk = b; e.emg = em; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_aspect(input logic [2:0] a);
    {green, yellow, red} = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    set_aspect(3'b001);
    step(2);
    expect_at(0, 0, 0, 1, 0, "reset_state");
    step(1);
    rstn = 1'b1;
    expect_at(2, 0, 0, 1, 0, "red_after_reset");
    step(3);

    // Green from stop: entry edge at +1, first step 4 edges later, 12 at +49.
    set_aspect(3'b100);
    expect_at(1,  0,  1, 0, 0, "accel_entry");
    expect_at(5,  1,  1, 0, 0, "first_step");
    expect_at(48, 11, 1, 0, 0, "accel_pre_top");
    expect_at(49, 12, 1, 0, 0, "accel_extra_cycle");
    expect_at(50, 12, 0, 0, 0, "cruise_12");
    expect_at(55, 12, 0, 0, 0, "cruise_hold");
    step(55);

    // Yellow at 12: down to 6 over 24 cycles, then cruise.
    set_aspect(3'b010);
    expect_at(1,  12, 0, 1, 0, "decel_entry");
    expect_at(24, 7,  0, 1, 0, "decel_mid");
    expect_at(25, 6,  0, 1, 0, "decel_at_6");
    expect_at(26, 6,  0, 0, 0, "cruise_6");
    expect_at(30, 6,  0, 0, 0, "cruise_6_hold");
    step(30);

    // Red at 6: 0 after 24 more cycles.
    set_aspect(3'b001);
    expect_at(24, 1, 0, 1, 0, "red_decel_1");
    expect_at(25, 0, 0, 1, 0, "red_decel_0");
    expect_at(26, 0, 0, 1, 0, "stopped");
    step(26);

    // Accelerate to 8 with step_cnt = 2, then reverse.
    set_aspect(3'b100);
    expect_at(35, 8, 1, 0, 0, "accel_8");
    step(35);
    set_aspect(3'b001);
    expect_at(1,  8, 0, 1, 0, "reverse_no_step");
    expect_at(4,  8, 0, 1, 0, "reverse_cnt_restart");
    expect_at(5,  7, 0, 1, 0, "reverse_first_step");
    expect_at(13, 5, 0, 1, 0, "decel_5");
    expect_at(14, 5, 0, 1, 0, "decel_5_hold");
    step(15);

    // Async reset mid-ramp: visible before the next rising edge.
    rstn = 1'b0;
    expect_at(0, 0, 0, 1, 0, "async_reset");
    step(2);
    rstn = 1'b1;
    expect_at(2, 0, 0, 1, 0, "post_reset_stopped");
    step(2);

    // Back up to 12, then illegal 110.
    set_aspect(3'b100);
    expect_at(50, 12, 0, 0, 0, "cruise_12_again");
    step(50);
    set_aspect(3'b110);
    expect_at(1,  12, 0, 1, 1, "emerg_entry");
    expect_at(12, 1,  0, 1, 1, "emerg_1");
    expect_at(13, 0,  0, 1, 1, "emerg_0");
    expect_at(20, 0,  0, 1, 1, "emerg_hold_illegal");
    step(20);
    set_aspect(3'b001);
    expect_at(1, 0, 0, 1, 0, "emerg_exit_red");
    step(2);

    // All-dark aspect while stopped, then green.
    set_aspect(3'b000);
    expect_at(1, 0, 0, 1, 1, "dark_emerg");
    expect_at(3, 0, 0, 1, 1, "dark_emerg_hold");
    step(3);
    set_aspect(3'b100);
    expect_at(1, 0, 0, 1, 0, "dark_exit_stopped");
    expect_at(2, 0, 1, 0, 0, "dark_then_accel");
    step(4);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/train_driver.md
# train_driver

On-board speed controller for the train that reads the trackside signal. It consumes the one-hot green/yellow/red aspect produced by the trackside signal block and ramps a train speed register toward an aspect-dependent target, asserting throttle or brake as it goes. Any aspect that is not exactly one-hot forces an emergency stop. The block sits on the train side of the same signalling interface, in the same clock domain as the signal block.

## Interface
- MAX_SPEED, 12: target speed for a green aspect; must be in 1..15.
- CAUTION_SPEED, 6: target speed for a yellow aspect; must be in 1..MAX_SPEED-1.
- ACCEL_DIV, 4: cycles per ±1 speed step in ACCEL/DECEL; must be ≥ 2.
- clk  input  1  single system clock, all state on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- green  input  1  signal aspect, clear.
- yellow  input  1  signal aspect, caution.
- red  input  1  signal aspect, danger.
- speed  output  4  current speed, unsigned, registered.
- throttle  output  1  high in ACCEL only.
- brake  output  1  high in STOPPED, DECEL and EMERGENCY.
- emergency  output  1  high in EMERGENCY only.

## Operation
- Aspect decode is combinational on the current inputs:
  - {g,y,r} = 100 → target MAX_SPEED.
  - 010 → target CAUTION_SPEED.
  - 001 → target 0.
  - Any other value is illegal.
- FSM states: S_STOPPED, S_ACCEL, S_CRUISE, S_DECEL, S_EMERGENCY.
- Next state from any non-emergency state, evaluated every cycle:
  - illegal aspect → S_EMERGENCY.
  - else speed < target → S_ACCEL.
  - else speed > target → S_DECEL.
  - else speed == 0 → S_STOPPED.
  - else → S_CRUISE.
- S_EMERGENCY:
  - Speed decrements by 1 every cycle until 0, then holds 0.
  - Exit to S_STOPPED only when speed == 0 and the aspect is legal. An illegal aspect keeps the block in S_EMERGENCY indefinitely.
- Step prescaler (step_cnt), 0..ACCEL_DIV-1:
  - Counts only in S_ACCEL and S_DECEL.
  - On the cycle it equals ACCEL_DIV-1, speed changes by +1 (ACCEL) or −1 (DECEL) and the counter wraps to 0.
  - Cleared to 0 on every state change and in every other state.
- Speed never exceeds MAX_SPEED and never underflows below 0. Steps that would overshoot the target cannot occur, because the state is re-evaluated every cycle.
- Outputs decode from the registered state only (Moore). speed is the register itself.

## Timing
- Reset (asynchronous assert, synchronous release on the first clk edge with rstn high):
  - state = S_STOPPED, speed = 0, step_cnt = 0.
  - throttle = 0, brake = 1, emergency = 0.
- Aspect change at cycle N: state updates at the edge ending cycle N, so outputs reflect it in cycle N+1.
- First speed step after entering S_ACCEL/S_DECEL: ACCEL_DIV cycles after entry.
- A full ramp from a to b takes |a−b|·ACCEL_DIV cycles, provided the aspect is stable.
- Direction reversal mid-ramp (e.g. green→red while accelerating): the state switches next edge and step_cnt restarts at 0. No step is taken on the switch edge.
- Arriving at the target: the step edge sets speed = target, and the state becomes S_CRUISE or S_STOPPED one edge later. The block spends exactly one extra cycle in ACCEL/DECEL with no step.
- Illegal aspect: S_EMERGENCY next edge. From speed s, 0 is reached s cycles later.
- Reset mid-ramp or mid-emergency: all registers return to reset values immediately, without waiting for clk.

## Structure
- Shared package train_pkg holds:
  - aspect_t, the one-hot {green,yellow,red} encodings, common with the trackside signal block.
  - driver_state_t enum, with 3-bit encoding.
  - the 4-bit speed_t typedef.
- One sub-module is natural: train_speed_ramp.
  - Contains step_cnt and the speed register.
  - Inputs: up, down, fast_down, clear_cnt.
  - Output: speed.
- The FSM and output decode stay in train_driver.

## Test plan
- Reset with the aspect held red → speed 0, brake 1, throttle 0, emergency 0. Assert rstn low mid-ramp at speed 5 → speed 0 and brake 1 before the next clk edge.
- Green from stop with defaults → throttle 1, speed reaches 12 after 48 ACCEL cycles, then S_CRUISE (throttle 0, brake 0), and speed holds at 12.
- Yellow at speed 12 → brake 1, speed 12→6 over 24 cycles, then cruise at 6. Then red → speed reaches 0 after 24 more cycles, state S_STOPPED, brake 1.
- Green→red reversal at speed 8 with step_cnt = 2 → S_DECEL next edge, no step on that edge, speed 7 four cycles later.
- Aspect 110 at speed 12 → emergency 1, brake 1, speed 0 after 12 cycles. It stays in emergency while the aspect is 110. Red applied → S_STOPPED next edge, emergency 0.
- Aspect 000 while stopped → S_EMERGENCY at speed 0. Green applied → S_STOPPED, then S_ACCEL on the following edge.
